alu_issue: RTL

Decode-and-issue stage directly upstream of the `alu` execute block. Accepts one RV32I ALU instruction (R-type `0110011` or I-type `0010011`) per cycle from fetch, reads a 32×32 register file, and presents registered `src1`/`src2`/`aluc`/`rd` to the ALU through a valid/ready handshake. Write-back from downstream returns through this block into the register file. A busy-bit scoreboard stalls read-after-write hazards.

---
 rtl/alu_pkg.sv | 88 ++++++++
 rtl/regfile.sv | 39 +++
 rtl/alu_issue.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and the RV32I ALU-instruction decoder used by alu_issue.
// The alu execute block imports the same package so aluc values stay in lockstep.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } aluc_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        legal;
        aluc_t       aluc;
        logic        use_rs2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

    function automatic aluc_t f3_to_aluc(input logic [2:0] f3, input logic alt);
        aluc_t a;
        case (f3)
            3'b000:  a = alt ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = alt ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       shift;
        logic       f7_ok;
        opcode    = instr[6:0];
        f3        = instr[14:12];
        f7        = instr[31:25];
        shift     = (f3 == 3'b001) || (f3 == 3'b101);
        // ALT funct7 only selects SUB or SRA; SLL/SLLI has no alternate form
        f7_ok     = (f7 == F7_BASE) ||
                    ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        d         = '0;
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.rd      = instr[11:7];
        case (opcode)
            OP_R: begin
                d.legal   = f7_ok;
                d.use_rs2 = 1'b1;
                d.aluc    = f3_to_aluc(f3, f7 == F7_ALT);
            end
            OP_I: begin
                if (shift) begin
                    d.legal = f7_ok && (f3 != 3'b000);
                    d.imm   = {27'b0, instr[24:20]};
                    d.aluc  = f3_to_aluc(f3, f7 == F7_ALT);
                end else begin
                    d.legal = 1'b1;
                    d.imm   = {{20{instr[31]}}, instr[31:20]};
                    d.aluc  = f3_to_aluc(f3, 1'b0);
                end
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, and write-first bypass so a same-cycle write-back is visible.
module regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0)
            rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0)
            rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
    end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage feeding the alu: decodes RV32I ALU ops, reads operands,
// tracks pending destinations in a busy-bit scoreboard and holds the issued op for the ALU.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] src1,
    output logic [XLEN-1:0] src2,
    output logic [3:0]      aluc,
    output logic [4:0]      rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    dec_t            dec;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic            haz_rs1;
    logic            haz_rs2;
    logic            hazard;
    logic            accept;
    logic            issue;

    assign dec = decode(in_instr);

    regfile #(.XLEN(XLEN)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (dec.rs1),
        .rdata1 (rdata1),
        .raddr2 (dec.rs2),
        .rdata2 (rdata2)
    );

    // A busy source being written back this cycle is served by the regfile bypass
    assign haz_rs1  = busy[dec.rs1] && !(wb_en && (wb_rd == dec.rs1));
    assign haz_rs2  = dec.use_rs2 && busy[dec.rs2] && !(wb_en && (wb_rd == dec.rs2));
    assign hazard   = dec.legal && (haz_rs1 || haz_rs2);
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && dec.legal;

    always_comb begin
        busy_nxt = busy;
        if (wb_en) busy_nxt[wb_rd] = 1'b0;
        if (issue) busy_nxt[dec.rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            src1      <= '0;
            src2      <= '0;
            aluc      <= 4'b0000;
            rd        <= 5'd0;
            illegal   <= 1'b0;
        end else begin
            illegal <= accept && !dec.legal;
            if (issue) begin
                out_valid <= 1'b1;
                src1      <= rdata1;
                src2      <= dec.use_rs2 ? rdata2 : dec.imm;
                aluc      <= dec.aluc;
                rd        <= dec.rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
